// File: rtl/lpm_pkg.sv
// rtl/lpm_pkg.sv - shared types and saturating arithmetic for the loop profile monitor
package lpm_pkg;

    localparam int MAX_CNT_W = 64;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_ACTIVE = 2'd1,
        CH_REPORT = 2'd2
    } ch_state_e;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_BUSY = 1'b1
    } txn_state_e;

    // Counters stick at the all-ones value of their own width rather than wrapping.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] val,
                                                     input int width);
        logic [MAX_CNT_W-1:0] max_val;
        max_val = (width >= MAX_CNT_W) ? '1 : ((MAX_CNT_W'(1) << width) - MAX_CNT_W'(1));
        sat_inc = (val >= max_val) ? max_val : (val + MAX_CNT_W'(1));
    endfunction

endpackage

// File: rtl/loop_profile_channel.sv
// rtl/loop_profile_channel.sv - one loop's trip/cycle profiler, holding its record until granted
module loop_profile_channel
    import lpm_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               finish_i,
    input  logic [STATE_W-1:0] cur_state_i,
    input  logic [STATE_W-1:0] iter_start_state_i,
    input  logic [STATE_W-1:0] iter_end_state_i,
    input  logic [STATE_W-1:0] quit_state_i,
    input  logic               one_state_loop_i,
    input  logic               grant_i,
    output logic               report_o,
    output logic [CNT_W-1:0]   trips_o,
    output logic [CNT_W-1:0]   cycles_o,
    output logic               reentry_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] trips_q, trips_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             hit_start, hit_quit, hit_trip;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(MAX_CNT_W'(v), CNT_W));
    endfunction

    assign hit_start = (cur_state_i == iter_start_state_i);
    assign hit_quit  = (cur_state_i == quit_state_i);
    // A single-state loop has no distinct end state, so every visit to the start state is a trip.
    assign hit_trip  = one_state_loop_i ? hit_start : (cur_state_i == iter_end_state_i);

    always_comb begin
        state_d   = state_q;
        trips_d   = trips_q;
        cycles_d  = cycles_q;
        reentry_o = 1'b0;
        case (state_q)
            CH_IDLE: begin
                if (!finish_i && hit_start) begin
                    state_d  = CH_ACTIVE;
                    cycles_d = CNT_W'(1);
                    trips_d  = one_state_loop_i ? CNT_W'(1) : '0;
                end
            end
            CH_ACTIVE: begin
                if (!finish_i) begin
                    if (hit_trip) begin
                        trips_d = cnt_inc(trips_q);
                    end
                    if (hit_quit) begin
                        state_d = CH_REPORT;
                    end else begin
                        cycles_d = cnt_inc(cycles_q);
                    end
                end
            end
            CH_REPORT: begin
                if (grant_i) begin
                    state_d = CH_IDLE;
                end
                if (!finish_i && hit_start) begin
                    reentry_o = 1'b1;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= CH_IDLE;
            trips_q  <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            trips_q  <= trips_d;
            cycles_q <= cycles_d;
        end
    end

    assign report_o = (state_q == CH_REPORT);
    assign trips_o  = trips_q;
    assign cycles_o = cycles_q;

endmodule

// File: rtl/loop_profile_monitor.sv
// rtl/loop_profile_monitor.sv - per-loop profiling channels, record arbiter and HLS transaction stats
module loop_profile_monitor
    import lpm_pkg::*;
#(
    parameter  int NUM_LOOPS = 2,
    parameter  int STATE_W   = 4,
    parameter  int CNT_W     = 32,
    localparam int ID_W      = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         finish,
    input  logic                         ap_start,
    input  logic                         ap_done,
    input  logic                         ap_continue,
    input  logic [STATE_W-1:0]           cur_state,
    input  logic [NUM_LOOPS*STATE_W-1:0] iter_start_state,
    input  logic [NUM_LOOPS*STATE_W-1:0] iter_end_state,
    input  logic [NUM_LOOPS*STATE_W-1:0] quit_state,
    input  logic [NUM_LOOPS-1:0]         one_state_loop,
    output logic                         rec_valid,
    input  logic                         rec_ready,
    output logic [ID_W-1:0]              rec_loop_id,
    output logic [CNT_W-1:0]             rec_trips,
    output logic [CNT_W-1:0]             rec_cycles,
    output logic [CNT_W-1:0]             txn_count,
    output logic [CNT_W-1:0]             last_latency,
    output logic                         rec_overflow,
    output logic                         drained
);

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(MAX_CNT_W'(v), CNT_W));
    endfunction

    logic [NUM_LOOPS-1:0] ch_report;
    logic [NUM_LOOPS-1:0] ch_grant;
    logic [NUM_LOOPS-1:0] ch_reentry;
    logic [CNT_W-1:0]     ch_trips  [NUM_LOOPS];
    logic [CNT_W-1:0]     ch_cycles [NUM_LOOPS];

    logic [ID_W-1:0] pri_id, sel_id;
    logic            lock_q;
    logic [ID_W-1:0] lock_id_q;
    logic            overflow_q;
    logic            drained_q;

    for (genvar i = 0; i < NUM_LOOPS; i++) begin : g_ch
        loop_profile_channel #(
            .STATE_W (STATE_W),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clock              (clock),
            .reset              (reset),
            .finish_i           (finish),
            .cur_state_i        (cur_state),
            .iter_start_state_i (iter_start_state[i*STATE_W +: STATE_W]),
            .iter_end_state_i   (iter_end_state[i*STATE_W +: STATE_W]),
            .quit_state_i       (quit_state[i*STATE_W +: STATE_W]),
            .one_state_loop_i   (one_state_loop[i]),
            .grant_i            (ch_grant[i]),
            .report_o           (ch_report[i]),
            .trips_o            (ch_trips[i]),
            .cycles_o           (ch_cycles[i]),
            .reentry_o          (ch_reentry[i])
        );
        assign ch_grant[i] = rec_valid && rec_ready && (sel_id == ID_W'(i));
    end

    always_comb begin
        pri_id = '0;
        for (int i = NUM_LOOPS - 1; i >= 0; i--) begin
            if (ch_report[i]) begin
                pri_id = ID_W'(i);
            end
        end
    end

    // A stalled record keeps its slot even if a lower-index channel starts reporting meanwhile.
    assign sel_id      = lock_q ? lock_id_q : pri_id;
    assign rec_valid   = |ch_report;
    assign rec_loop_id = rec_valid ? sel_id : '0;
    assign rec_trips   = rec_valid ? ch_trips[sel_id] : '0;
    assign rec_cycles  = rec_valid ? ch_cycles[sel_id] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            overflow_q <= 1'b0;
            drained_q  <= 1'b0;
        end else begin
            lock_q     <= rec_valid && !rec_ready;
            lock_id_q  <= sel_id;
            overflow_q <= overflow_q | (|ch_reentry);
            drained_q  <= finish && !(|ch_report);
        end
    end

    assign rec_overflow = overflow_q;
    assign drained      = drained_q;

    txn_state_e       txn_state_q, txn_state_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] txn_count_q, txn_count_d;
    logic [CNT_W-1:0] last_lat_q, last_lat_d;

    // The latency counter includes the current cycle, so a completion records lat_q + 1.
    always_comb begin
        txn_state_d = txn_state_q;
        lat_d       = lat_q;
        txn_count_d = txn_count_q;
        last_lat_d  = last_lat_q;
        if (!finish) begin
            case (txn_state_q)
                T_IDLE: begin
                    if (ap_start) begin
                        txn_state_d = T_BUSY;
                        lat_d       = CNT_W'(1);
                    end
                end
                T_BUSY: begin
                    if (ap_done && ap_continue) begin
                        txn_count_d = cnt_inc(txn_count_q);
                        last_lat_d  = cnt_inc(lat_q);
                        if (ap_start) begin
                            lat_d = CNT_W'(1);
                        end else begin
                            txn_state_d = T_IDLE;
                        end
                    end else begin
                        lat_d = cnt_inc(lat_q);
                    end
                end
                default: txn_state_d = T_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            txn_state_q <= T_IDLE;
            lat_q       <= '0;
            txn_count_q <= '0;
            last_lat_q  <= '0;
        end else begin
            txn_state_q <= txn_state_d;
            lat_q       <= lat_d;
            txn_count_q <= txn_count_d;
            last_lat_q  <= last_lat_d;
        end
    end

    assign txn_count    = txn_count_q;
    assign last_latency = last_lat_q;

endmodule

// File: doc/loop_profile_monitor.md
LOOP_PROFILE_MONITOR -- requirements
Module: loop_profile_monitor

Interface
REQ-001 Parameter NUM_LOOPS, default 2, number of independently profiled sequential loops (1..8).
REQ-002 Parameter STATE_W, default 4, width of the design-under-profile FSM state vector.
REQ-003 Parameter CNT_W, default 32, width of every counter and record field.
REQ-004 clock  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 finish  in  1  end-of-run; freezes all counting.
REQ-007 ap_start / ap_done / ap_continue  in  1 each  module-level HLS handshake under observation.
REQ-008 cur_state  in  STATE_W  current FSM state of the observed module.
REQ-009 iter_start_state / iter_end_state / quit_state  in  NUM_LOOPS*STATE_W  per-loop state encodings; loop i occupies slice [i*STATE_W +: STATE_W].
REQ-010 one_state_loop  in  NUM_LOOPS  loop i whose start and end state are the same state.
REQ-011 rec_valid  out  1 ; rec_ready  in  1  loop-record stream handshake.
REQ-012 rec_loop_id  out  $clog2(NUM_LOOPS) (min 1) ; rec_trips  out  CNT_W ; rec_cycles  out  CNT_W  record payload.
REQ-013 txn_count  out  CNT_W ; last_latency  out  CNT_W  module transaction statistics.
REQ-014 rec_overflow  out  1  sticky, a loop record was lost.
REQ-015 drained  out  1  finish seen and no record pending.

Function
REQ-016 Each loop channel SHALL run FSM IDLE -> ACTIVE -> REPORT -> IDLE.
REQ-017 IDLE -> ACTIVE when cur_state == iter_start_state[i]; trips and cycles cleared, cycles set to 1 on that cycle.
REQ-018 In ACTIVE, cycles SHALL increment every cycle; trips SHALL increment on each cycle cur_state == iter_end_state[i].
REQ-019 With one_state_loop[i]=1, trips SHALL increment on every ACTIVE cycle cur_state == iter_start_state[i], including the entry cycle.
REQ-020 ACTIVE -> REPORT when cur_state == quit_state[i]; the quit cycle is not counted in cycles; end-state and quit on the same cycle counts the trip, then leaves ACTIVE.
REQ-021 Record presentation: rec_valid SHALL assert the cycle after REPORT entry; payload SHALL be stable while rec_valid && !rec_ready.
REQ-022 Multiple channels in REPORT: fixed priority, lowest loop index first; one record per rec_valid && rec_ready cycle; that channel returns to IDLE the next cycle.
REQ-023 Channel in REPORT detecting a new iter_start SHALL keep its pending record, ignore the re-entry, and set rec_overflow.
REQ-024 All counters SHALL saturate at all-ones, never wrap.
REQ-025 Transaction FSM T_IDLE/T_BUSY: ap_start in T_IDLE -> T_BUSY, latency counter = 1; increments each T_BUSY cycle.
REQ-026 ap_done && ap_continue in T_BUSY: txn_count += 1, last_latency = latency counter, -> T_IDLE; if ap_start also high, stay T_BUSY with latency counter = 1.
REQ-027 ap_done with ap_continue=0 SHALL be ignored until ap_continue rises.
REQ-028 finish=1: all counters and channel FSMs freeze except REPORT draining; ACTIVE channels are not reported; drained = finish && no channel in REPORT, registered.

Reset
REQ-029 Reset SHALL force all channels IDLE, T_IDLE, all counters 0, rec_valid 0, rec_loop_id 0, rec_trips 0, rec_cycles 0, txn_count 0, last_latency 0, rec_overflow 0, drained 0.
REQ-030 Reset mid-record SHALL discard the pending record with no handshake completion.

Structure
REQ-031 Shared package lpm_pkg SHALL hold the channel-state enum, transaction-state enum and saturating-increment function.
REQ-032 Per-loop channel SHALL be sub-module loop_profile_channel, instantiated NUM_LOOPS times by generate; arbiter and transaction FSM stay in top.

Verification
REQ-033 Loop0 start=2,end=4,quit=1; sequence 2,3,4,2,3,4,1 -> one record id0, trips=2, cycles=6.
REQ-034 Loops 0 and 1 quit same cycle, rec_ready=1 -> id0 then id1 on consecutive cycles.
REQ-035 rec_ready=0 for 10 cycles, loop0 re-entered -> payload stable, rec_overflow=1, original record delivered.
REQ-036 ap_start at t, ap_done&&ap_continue at t+5 with ap_start=1 -> txn_count=1, last_latency=6, next transaction latency restarts at 1.
REQ-037 one_state_loop[0]=1, state 2 held 5 cycles then quit -> trips=5, cycles=5.
REQ-038 Reset asserted with rec_valid=1 -> next cycle rec_valid=0, all outputs at REQ-029 values.
